// File: rtl/alarm_sequencer.sv
// Alarm control FSM: turns the comparator's match level and the snooze/stop
// buttons into ring/snooze sequencing, buzzer drive and status outputs.
module alarm_sequencer #(
    parameter int RING_TICKS   = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZES  = 3,
    parameter int CNT_WIDTH    = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       enable,
    input  logic       match,
    input  logic       snooze_btn,
    input  logic       stop_btn,
    output logic       buzzer,
    output logic       ringing,
    output logic       snoozing,
    output logic [2:0] snooze_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_DISARMED = 2'b00,
        ST_ARMED    = 2'b01,
        ST_RING     = 2'b10,
        ST_SNOOZE   = 2'b11
    } state_t;

    localparam logic [CNT_WIDTH-1:0] RING_LAST   = CNT_WIDTH'(RING_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] SNOOZE_LAST = CNT_WIDTH'(SNOOZE_TICKS - 1);
    localparam logic [2:0]           SNZ_MAX     = 3'(MAX_SNOOZES);

    state_t               r_state;
    state_t               w_state_nxt;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] w_cnt_nxt;
    logic [2:0]           r_scount;
    logic [2:0]           w_scount_nxt;
    logic                 r_match_q;
    logic                 r_snz_q;
    logic                 r_stp_q;
    logic                 r_buzzer;
    logic                 r_ringing;
    logic                 r_snoozing;
    logic                 w_buzzer_nxt;
    logic                 w_ringing_nxt;
    logic                 w_snoozing_nxt;
    logic                 w_ring_tick;
    logic                 w_match_rise;
    logic                 w_snz_rise;
    logic                 w_stp_rise;

    assign w_match_rise = match      & ~r_match_q;
    assign w_snz_rise   = snooze_btn & ~r_snz_q;
    assign w_stp_rise   = stop_btn   & ~r_stp_q;

    assign state        = r_state;
    assign buzzer       = r_buzzer;
    assign ringing      = r_ringing;
    assign snoozing     = r_snoozing;
    assign snooze_count = r_scount;

    // State, counters, edge-detect copies and registered outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_DISARMED;
            r_cnt      <= '0;
            r_scount   <= 3'd0;
            r_match_q  <= 1'b0;
            r_snz_q    <= 1'b0;
            r_stp_q    <= 1'b0;
            r_buzzer   <= 1'b0;
            r_ringing  <= 1'b0;
            r_snoozing <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_scount   <= w_scount_nxt;
            r_match_q  <= match;
            r_snz_q    <= snooze_btn;
            r_stp_q    <= stop_btn;
            r_buzzer   <= w_buzzer_nxt;
            r_ringing  <= w_ringing_nxt;
            r_snoozing <= w_snoozing_nxt;
        end
    end

    // Next-state logic; an event in a cycle swallows a coincident tick.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_scount_nxt = r_scount;
        w_ring_tick  = 1'b0;
        if (!enable) begin
            w_state_nxt  = ST_DISARMED;
            w_cnt_nxt    = '0;
            w_scount_nxt = 3'd0;
        end else begin
            case (r_state)
                ST_DISARMED: begin
                    w_state_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    w_cnt_nxt    = '0;
                    w_scount_nxt = 3'd0;
                    if (w_match_rise) begin
                        w_state_nxt = ST_RING;
                    end else begin
                        w_state_nxt = ST_ARMED;
                    end
                end
                ST_RING: begin
                    if (w_stp_rise || (w_snz_rise && (r_scount >= SNZ_MAX))) begin
                        w_state_nxt  = ST_ARMED;
                        w_cnt_nxt    = '0;
                        w_scount_nxt = 3'd0;
                    end else if (w_snz_rise) begin
                        w_state_nxt  = ST_SNOOZE;
                        w_cnt_nxt    = '0;
                        w_scount_nxt = r_scount + 3'd1;
                    end else if (tick) begin
                        if (r_cnt == RING_LAST) begin
                            w_state_nxt  = ST_ARMED;
                            w_cnt_nxt    = '0;
                            w_scount_nxt = 3'd0;
                        end else begin
                            w_cnt_nxt   = r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            w_ring_tick = 1'b1;
                        end
                    end else begin
                        w_state_nxt = ST_RING;
                    end
                end
                ST_SNOOZE: begin
                    if (w_stp_rise) begin
                        w_state_nxt  = ST_ARMED;
                        w_cnt_nxt    = '0;
                        w_scount_nxt = 3'd0;
                    end else if (tick) begin
                        if (r_cnt == SNOOZE_LAST) begin
                            w_state_nxt = ST_RING;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        w_state_nxt = ST_SNOOZE;
                    end
                end
                default: begin
                    w_state_nxt  = ST_DISARMED;
                    w_cnt_nxt    = '0;
                    w_scount_nxt = 3'd0;
                end
            endcase
        end
    end

    // Output decode from the next state; buzzer starts high on RING entry.
    always_comb begin
        w_ringing_nxt  = (w_state_nxt == ST_RING);
        w_snoozing_nxt = (w_state_nxt == ST_SNOOZE);
        if (w_state_nxt == ST_RING) begin
            if (r_state != ST_RING) begin
                w_buzzer_nxt = 1'b1;
            end else if (w_ring_tick) begin
                w_buzzer_nxt = ~r_buzzer;
            end else begin
                w_buzzer_nxt = r_buzzer;
            end
        end else begin
            w_buzzer_nxt = 1'b0;
        end
    end

endmodule

// File: tb/tb_alarm_sequencer.sv
// Bench for alarm_sequencer: directed scenarios then random stimulus, all
// compared against a tick-counting reference model every cycle.
module tb_alarm_sequencer;

    localparam int RT = 4;
    localparam int ST = 3;
    localparam int MS = 2;

    localparam int M_DIS  = 0;
    localparam int M_ARM  = 1;
    localparam int M_RING = 2;
    localparam int M_SNZ  = 3;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b0;
    logic       enable = 1'b0;
    logic       match = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       buzzer;
    logic       ringing;
    logic       snoozing;
    logic [2:0] snooze_count;
    logic [1:0] state;

    int n_asserts = 0;
    int n_fail    = 0;

    int m_mode  = M_DIS;
    int m_ticks = 0;
    int m_snz   = 0;
    bit m_pm = 1'b0, m_ps = 1'b0, m_pp = 1'b0;

    alarm_sequencer #(
        .RING_TICKS  (RT),
        .SNOOZE_TICKS(ST),
        .MAX_SNOOZES (MS),
        .CNT_WIDTH   (9)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .tick        (tick),
        .enable      (enable),
        .match       (match),
        .snooze_btn  (snooze_btn),
        .stop_btn    (stop_btn),
        .buzzer      (buzzer),
        .ringing     (ringing),
        .snoozing    (snoozing),
        .snooze_count(snooze_count),
        .state       (state)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic go_armed();
        m_mode  = M_ARM;
        m_ticks = 0;
        m_snz   = 0;
    endtask

    // Reference: ring/snooze lengths counted in ticks, buzzer from tick parity.
    task automatic model_update();
        bit mr, sr, pr;
        mr = match && !m_pm;
        sr = snooze_btn && !m_ps;
        pr = stop_btn && !m_pp;
        if (reset) begin
            m_mode = M_DIS; m_ticks = 0; m_snz = 0;
            m_pm = 1'b0; m_ps = 1'b0; m_pp = 1'b0;
            return;
        end
        m_pm = match; m_ps = snooze_btn; m_pp = stop_btn;
        if (!enable) begin
            m_mode = M_DIS; m_ticks = 0; m_snz = 0;
        end else if (m_mode == M_DIS) begin
            m_mode = M_ARM;
        end else if (m_mode == M_ARM) begin
            if (mr) begin m_mode = M_RING; m_ticks = 0; m_snz = 0; end
        end else if (m_mode == M_RING) begin
            if (pr) go_armed();
            else if (sr && m_snz < MS) begin m_mode = M_SNZ; m_ticks = 0; m_snz++; end
            else if (sr) go_armed();
            else if (tick) begin
                m_ticks++;
                if (m_ticks == RT) go_armed();
            end
        end else begin
            if (pr) go_armed();
            else if (tick) begin
                m_ticks++;
                if (m_ticks == ST) begin m_mode = M_RING; m_ticks = 0; end
            end
        end
    endtask

    task automatic step();
        logic [1:0] es;
        @(posedge clock);
        model_update();
        #1;
        es = 2'(m_mode);
        chk("state", {6'd0, state}, {6'd0, es});
        chk("buzzer", {7'd0, buzzer}, {7'd0, (m_mode == M_RING) && (m_ticks % 2 == 0)});
        chk("ringing", {7'd0, ringing}, {7'd0, m_mode == M_RING});
        chk("snoozing", {7'd0, snoozing}, {7'd0, m_mode == M_SNZ});
        chk("snooze_count", {5'd0, snooze_count}, 8'(m_snz));
    endtask

    task automatic tick_step();
        tick = 1'b1; step(); tick = 1'b0;
    endtask

    initial begin
        // 1: reset then enable
        step(); step();
        chk("t1_reset_state", {6'd0, state}, 8'h00);
        reset = 1'b0; enable = 1'b1;
        step();
        chk("t1_armed", {6'd0, state}, 8'h01);

        // 2: match edge, ring runs out after RT ticks
        match = 1'b1; step();
        chk("t2_ring", {6'd0, state}, 8'h02);
        chk("t2_buz0", {7'd0, buzzer}, 8'h01);
        for (int i = 0; i < 5; i++) begin
            tick_step(); step();
        end
        chk("t2_autostop", {6'd0, state}, 8'h01);

        // 3: two snoozes with expiry, third snooze acts as stop
        match = 1'b0; step(); match = 1'b1; step();
        for (int s = 0; s < 2; s++) begin
            snooze_btn = 1'b1; step(); snooze_btn = 1'b0; step();
            chk("t3_count", {5'd0, snooze_count}, 8'(s + 1));
            for (int i = 0; i < ST; i++) tick_step();
            chk("t3_rering", {6'd0, state}, 8'h02);
        end
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        chk("t3_third", {6'd0, state}, 8'h01);
        chk("t3_cnt0", {5'd0, snooze_count}, 8'h00);

        // 4: snooze and stop together
        match = 1'b0; step(); match = 1'b1; step();
        snooze_btn = 1'b1; stop_btn = 1'b1; step();
        chk("t4_state", {6'd0, state}, 8'h01);
        chk("t4_snz", {7'd0, snoozing}, 8'h00);
        snooze_btn = 1'b0; stop_btn = 1'b0; step();

        // 5: match held across enable does not trigger
        match = 1'b0; enable = 1'b0; step();
        match = 1'b1; step();
        enable = 1'b1; step(); step(); step();
        chk("t5_noring", {6'd0, state}, 8'h01);
        match = 1'b0; step(); match = 1'b1; step();
        chk("t5_ring", {6'd0, state}, 8'h02);

        // 6: reset mid-snooze, then enable drop mid-ring
        snooze_btn = 1'b1; step(); snooze_btn = 1'b0;
        tick_step();
        tick = 1'b1; reset = 1'b1; step(); tick = 1'b0; reset = 1'b0;
        chk("t6_reset", {6'd0, state}, 8'h00);
        step(); match = 1'b0; step(); match = 1'b1; step();
        chk("t6_ring", {6'd0, state}, 8'h02);
        enable = 1'b0; step();
        chk("t6_dis", {6'd0, state}, 8'h00);
        chk("t6_buz", {7'd0, buzzer}, 8'h00);
        enable = 1'b1; step();

        // random phase
        for (int c = 0; c < 4000; c++) begin
            reset  = ($urandom_range(0, 299) == 0);
            enable = ($urandom_range(0, 79) != 0);
            tick   = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 11) == 0) match = ~match;
            if ($urandom_range(0, 5) == 0) snooze_btn = ~snooze_btn;
            if ($urandom_range(0, 17) == 0) stop_btn = ~stop_btn;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
